// File: rtl/pwm_pkg.sv
// Shared width defaults and direction encoding for the PWM timebase and generator.
package pwm_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int PSC_W_DEF = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every prescale+1 enabled clk cycles.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    localparam logic [PSC_W-1:0] PSC_ONE = 1;

    logic [PSC_W-1:0] psc_cnt_reg;
    logic             hit;

    // >= rather than == so a prescale lowered below psc_cnt still ticks at once.
    assign hit  = (psc_cnt_reg >= prescale);
    assign tick = en && !clr && !rst && hit;

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            psc_cnt_reg <= '0;
        end else if (hit) begin
            psc_cnt_reg <= '0;
        end else begin
            psc_cnt_reg <= psc_cnt_reg + PSC_ONE;
        end
    end

endmodule

// File: rtl/pwm_counter.sv
// PWM timebase: prescaled up/down counter with shadowed period and wrap pulses.
module pwm_counter
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    input  logic             up_ndown,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
    output logic [CNT_W-1:0] count_val,
    output logic [CNT_W-1:0] period_act,
    output logic             ovf,
    output logic             udf
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             tick;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] period_act_reg;
    logic             ovf_reg;
    logic             udf_reg;

    pwm_prescaler #(
        .PSC_W    (PSC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .prescale (prescale),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg      <= '0;
            period_act_reg <= '0;
            ovf_reg        <= 1'b0;
            udf_reg        <= 1'b0;
        end else begin
            ovf_reg <= 1'b0;
            udf_reg <= 1'b0;
            if (cnt_clr) begin
                count_reg      <= '0;
                period_act_reg <= period;
            end else if (!cnt_en) begin
                // Shadow is transparent while the timebase is stopped.
                period_act_reg <= period;
            end else if (tick) begin
                if (up_ndown == DIR_UP) begin
                    if (count_reg >= period_act_reg) begin
                        count_reg      <= '0;
                        ovf_reg        <= 1'b1;
                        period_act_reg <= period;
                    end else begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end else begin
                    // Out-of-range counts (period shrunk while counting up) reload too.
                    if (count_reg == '0 || count_reg > period_act_reg) begin
                        count_reg      <= period;
                        udf_reg        <= 1'b1;
                        period_act_reg <= period;
                    end else begin
                        count_reg <= count_reg - CNT_ONE;
                    end
                end
            end
        end
    end

    assign count_val  = count_reg;
    assign period_act = period_act_reg;
    assign ovf        = ovf_reg;
    assign udf        = udf_reg;

endmodule

// File: tb/tb_pwm_counter.sv
// Self-checking bench for pwm_counter: directed test-plan sequences plus randomized traffic vs. a model.
module tb_pwm_counter;

    localparam int CNT_W = 16;
    localparam int PSC_W = 8;

    logic             clk;
    logic             rst;
    logic             cnt_en;
    logic             cnt_clr;
    logic             up_ndown;
    logic [CNT_W-1:0] period;
    logic [PSC_W-1:0] prescale;
    logic [CNT_W-1:0] count_val;
    logic [CNT_W-1:0] period_act;
    logic             ovf;
    logic             udf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state (plain integers).
    int m_cnt  = 0;
    int m_pact = 0;
    int m_psc  = 0;
    int m_ovf  = 0;
    int m_udf  = 0;

    pwm_counter #(
        .CNT_W      (CNT_W),
        .PSC_W      (PSC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .up_ndown   (up_ndown),
        .period     (period),
        .prescale   (prescale),
        .count_val  (count_val),
        .period_act (period_act),
        .ovf        (ovf),
        .udf        (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock: predict from the spec rules, then compare all outputs.
    task automatic step();
        int n_cnt  = m_cnt;
        int n_pact = m_pact;
        int n_psc  = m_psc;
        int n_ovf  = 0;
        int n_udf  = 0;
        int per    = int'(period);
        if (rst) begin
            n_cnt = 0; n_pact = 0; n_psc = 0;
        end else if (cnt_clr) begin
            n_cnt = 0; n_psc = 0; n_pact = per;
        end else if (!cnt_en) begin
            n_psc = 0; n_pact = per;
        end else if (m_psc >= int'(prescale)) begin
            n_psc = 0;
            if (up_ndown) begin
                if (m_cnt >= m_pact) begin
                    n_cnt = 0; n_ovf = 1; n_pact = per;
                end else begin
                    n_cnt = m_cnt + 1;
                end
            end else if (m_cnt == 0 || m_cnt > m_pact) begin
                n_cnt = per; n_udf = 1; n_pact = per;
            end else begin
                n_cnt = m_cnt - 1;
            end
        end else begin
            n_psc = m_psc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        m_cnt = n_cnt; m_pact = n_pact; m_psc = n_psc; m_ovf = n_ovf; m_udf = n_udf;
        $display("cyc=%0d rst=%0b clr=%0b en=%0b up=%0b per=%0d psc=%0d -> count=%0d pact=%0d ovf=%0b udf=%0b",
                 cyc, rst, cnt_clr, cnt_en, up_ndown, period, prescale,
                 count_val, period_act, ovf, udf);
        check("count_val",  int'(count_val),  m_cnt);
        check("period_act", int'(period_act), m_pact);
        check("ovf",        int'(ovf),        m_ovf);
        check("udf",        int'(udf),        m_udf);
    endtask

    int exp_up[6]   = '{1, 2, 3, 4, 0, 1};
    int exp_dn[5]   = '{3, 2, 1, 0, 3};
    int exp_psc[7]  = '{0, 0, 1, 1, 1, 2, 2};

    initial begin
        rst = 1'b1; cnt_en = 1'b0; cnt_clr = 1'b0; up_ndown = 1'b1;
        period = '0; prescale = '0;

        // Reset for two cycles.
        step();
        step();
        check("rst_count", int'(count_val), 0);
        check("rst_pact",  int'(period_act), 0);

        // Load period while disabled, then count up with prescale 0.
        rst = 1'b0; period = 16'd4;
        step();
        check("load_pact", int'(period_act), 4);
        cnt_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("up_seq", int'(count_val), exp_up[i]);
            check("up_ovf", int'(ovf), (exp_up[i] == 0) ? 1 : 0);
        end

        // Clear with period 3, then count down from 0.
        cnt_clr = 1'b1; period = 16'd3;
        step();
        check("clr_count", int'(count_val), 0);
        cnt_clr = 1'b0; up_ndown = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("dn_seq", int'(count_val), exp_dn[i]);
            check("dn_udf", int'(udf), (exp_dn[i] == 3) ? 1 : 0);
        end

        // Prescaler of 2 in up mode from a cleared count.
        cnt_clr = 1'b1; up_ndown = 1'b1; prescale = 8'd2;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check("psc_seq", int'(count_val), exp_psc[i]);
        end

        // Disable hold: period_act tracks period, count holds.
        cnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            period = 16'(10 + i);
            step();
            check("hold_count", int'(count_val), 2);
            check("hold_pact",  int'(period_act), 10 + i);
        end
        cnt_en = 1'b1; prescale = 8'd1;
        step();
        check("reen_1", int'(count_val), 2);
        step();
        check("reen_2", int'(count_val), 3);

        // rst wins over cnt_clr.
        rst = 1'b1; cnt_clr = 1'b1;
        step();
        check("rst_clr_pact", int'(period_act), 0);
        rst = 1'b0; cnt_clr = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            cnt_clr  = ($urandom_range(0, 49) == 0);
            cnt_en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) up_ndown = ~up_ndown;
            if ($urandom_range(0, 9) == 0)  period   = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 24) == 0) prescale = 8'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
